// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types and default widths for the BRAM port arbiter.
package bram_arb_pkg;
  localparam int DEF_LANES = 3;
  localparam int DEF_WORD_W = 128;
  localparam int DEF_BE_W = DEF_WORD_W / 8;
  localparam int DEF_DATA_W = DEF_LANES * DEF_WORD_W;
  typedef enum logic {IDLE, CLEAR} arb_state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_CACHE, TAG_FEED} tag_t;
endpackage

// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: requester handshakes, bulk-clear control and the shared BRAM port.
interface bram_port_arbiter_if
  import bram_arb_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int WORD_W = DEF_WORD_W
);
  logic cache_req, cache_ack, cache_rvalid;
  logic [31:0] cache_pt;
  logic [LANES*WORD_W-1:0] cache_rdata;
  logic feed_req, feed_ack, feed_rvalid;
  logic [31:0] feed_pt;
  logic [LANES*WORD_W-1:0] feed_rdata;
  logic wr_req, wr_ack;
  logic [31:0] wr_pt;
  logic [LANES*WORD_W-1:0] wr_data;
  logic [WORD_W/8-1:0] wr_be;
  logic clr_start, clr_done, busy;
  logic [31:0] clr_words;
  logic [31:0] bram_addr;
  logic bram_en;
  logic [WORD_W/8-1:0] bram_we;
  logic [LANES*WORD_W-1:0] bram_din, bram_dout;
  modport master (
    input cache_req, cache_pt, feed_req, feed_pt, wr_req, wr_pt, wr_data, wr_be,
          clr_start, clr_words, bram_dout,
    output cache_ack, cache_rvalid, cache_rdata, feed_ack, feed_rvalid, feed_rdata, wr_ack,
           clr_done, busy, bram_addr, bram_en, bram_we, bram_din
  );
  modport slave (
    output cache_req, cache_pt, feed_req, feed_pt, wr_req, wr_pt, wr_data, wr_be,
           clr_start, clr_words, bram_dout,
    input cache_ack, cache_rvalid, cache_rdata, feed_ack, feed_rvalid, feed_rdata, wr_ack,
          clr_done, busy, bram_addr, bram_en, bram_we, bram_din
  );
endinterface

// File: rtl/bram_rd_tag_pipe.sv
// bram_rd_tag_pipe: RD_LAT-deep tag shift register aligning read tags with BRAM output data.
module bram_rd_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clock,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);
  tag_t stage [RD_LAT];
  always_ff @(posedge clock)
    if (reset) stage <= '{default: TAG_NONE};
    else begin
      stage[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  assign tag_out = stage[RD_LAT-1];
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one lockstep BRAM port between cache, writer and feeder, plus bulk clear.
// Optional ARB_STARVE_GUARD_EN forces a feeder grant after STARVE_LIMIT consecutive denied cycles.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int WORD_W = DEF_WORD_W,
  parameter int PTS_LOG2 = 3,
  parameter int RD_LAT = 1,
  parameter int STARVE_LIMIT = 8
) (
  input logic clock,
  input logic reset,
  bram_port_arbiter_if.master bus
);
  arb_state_t state, state_n;
  tag_t issue_tag, ret_tag;
  logic [31:0] cnt, words, pt;
  logic idle_ok, starve, g_cache, g_wr, g_feed, clr_wr;
  logic [LANES*WORD_W-1:0] cache_hold, feed_hold;
`ifdef ARB_STARVE_GUARD_EN
  logic [31:0] starve_cnt;
  assign starve = bus.feed_req && starve_cnt == 32'(STARVE_LIMIT);
  always_ff @(posedge clock)
    if (reset || !bus.feed_req || g_feed) starve_cnt <= '0;
    else if (state == IDLE && !starve) starve_cnt <= starve_cnt + 32'd1;
`else
  assign starve = 1'b0;
`endif
  // clr_start outranks every requester; reset masks all combinational outputs
  assign idle_ok = !reset && state == IDLE && !bus.clr_start;
  assign g_cache = idle_ok && bus.cache_req && !starve;
  assign g_wr = idle_ok && bus.wr_req && !bus.cache_req && !starve;
  assign g_feed = idle_ok && bus.feed_req && (starve || !(bus.cache_req || bus.wr_req));
  assign clr_wr = state == CLEAR && cnt != words;
  assign pt = g_cache ? bus.cache_pt : g_wr ? bus.wr_pt : bus.feed_pt;
  assign bus.cache_ack = g_cache;
  assign bus.wr_ack = g_wr;
  assign bus.feed_ack = g_feed;
  always_comb begin
    state_n = state == IDLE ? (bus.clr_start ? CLEAR : IDLE) : (clr_wr ? CLEAR : IDLE);
    bus.busy = !reset && clr_wr;
    bus.clr_done = !reset && state == CLEAR && !clr_wr;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      words <= '0;
      issue_tag <= TAG_NONE;
      bus.bram_addr <= '0;
      bus.bram_en <= 1'b0;
      bus.bram_we <= '0;
      bus.bram_din <= '0;
    end else begin
      state <= state_n;
      cnt <= clr_wr ? cnt + 32'd1 : '0;
      if (state == IDLE && bus.clr_start) words <= bus.clr_words;
      issue_tag <= g_cache ? TAG_CACHE : g_feed ? TAG_FEED : TAG_NONE;
      bus.bram_en <= clr_wr || g_cache || g_wr || g_feed;
      bus.bram_addr <= clr_wr ? cnt : pt >> PTS_LOG2;
      bus.bram_we <= clr_wr ? '1 : g_wr ? bus.wr_be : '0;
      bus.bram_din <= g_wr ? bus.wr_data : '0;
    end
  bram_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clock  (clock),
    .reset  (reset),
    .tag_in (issue_tag),
    .tag_out(ret_tag)
  );
  assign bus.cache_rvalid = !reset && ret_tag == TAG_CACHE;
  assign bus.feed_rvalid = !reset && ret_tag == TAG_FEED;
  assign bus.cache_rdata = bus.cache_rvalid ? bus.bram_dout : cache_hold;
  assign bus.feed_rdata = bus.feed_rvalid ? bus.bram_dout : feed_hold;
  always_ff @(posedge clock)
    if (reset) begin
      cache_hold <= '0;
      feed_hold <= '0;
    end else begin
      if (bus.cache_rvalid) cache_hold <= bus.bram_dout;
      if (bus.feed_rvalid) feed_hold <= bus.bram_dout;
    end
endmodule
